// File: rtl/decode_pkg.sv
// decode_pkg: micro-op layout, opcode/funct constants and reservation station encodings.
package decode_pkg;
  typedef struct packed {
    logic [31:0] pc;
    logic [5:0]  operation;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        has_rd;
    logic        has_rs1;
    logic        has_rs2;
    logic [31:0] imm;
    logic [3:0]  rs_station;
    logic [5:0]  alu_fn;
    logic        illegal;
  } uop_t;
  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_ADDIU   = 6'b001001;
  localparam logic [5:0] OP_ANDI    = 6'b001100;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] OP_LW      = 6'b100011;
  localparam logic [5:0] OP_SW      = 6'b101011;
  localparam logic [5:0] OP_LUI     = 6'b001111;
  localparam logic [5:0] FN_ADDU    = 6'b100001;
  localparam logic [5:0] FN_AND     = 6'b100100;
  localparam logic [5:0] FN_DIV     = 6'b011010;
  localparam logic [5:0] FN_MFHI    = 6'b010000;
  localparam logic [5:0] FN_MFLO    = 6'b010010;
  localparam logic [3:0] ST_NONE    = 4'd0;
  localparam logic [3:0] ST_ALU     = 4'd1;
  localparam logic [3:0] ST_MDU     = 4'd2;
  localparam logic [3:0] ST_BRI     = 4'd3;
  localparam logic [3:0] ST_LSU     = 4'd4;
endpackage

// File: rtl/uop_decode.sv
// uop_decode: pure combinational instruction-to-uop decoder; unused fields stay zero.
module uop_decode
  import decode_pkg::*;
(
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  output uop_t        uop
);
  logic [5:0]  op, fn;
  logic [4:0]  rs, rt, rd;
  logic [31:0] simm, zimm;
  logic        unused_shamt;
  assign op           = instr[31:26];
  assign fn           = instr[5:0];
  assign rs           = instr[25:21];
  assign rt           = instr[20:16];
  assign rd           = instr[15:11];
  assign simm         = {{16{instr[15]}}, instr[15:0]};
  assign zimm         = {16'h0, instr[15:0]};
  assign unused_shamt = ^instr[10:6];
  always_comb begin
    uop    = '0;
    uop.pc = pc;
    case (op)
      OP_ADDIU, OP_ANDI, OP_LW: begin
        uop.operation  = op;
        uop.rs1        = rs;
        uop.has_rs1    = 1'b1;
        uop.rd         = rt;
        uop.has_rd     = 1'b1;
        uop.imm        = op == OP_ANDI ? zimm : simm;
        uop.rs_station = op == OP_LW ? ST_LSU : ST_ALU;
        uop.alu_fn     = op == OP_ANDI ? 6'd2 : 6'd0;
      end
      OP_BEQ, OP_SW: begin
        uop.operation  = op;
        uop.rs1        = rs;
        uop.has_rs1    = 1'b1;
        uop.rs2        = rt;
        uop.has_rs2    = 1'b1;
        uop.imm        = simm;
        uop.rs_station = op == OP_SW ? ST_LSU : ST_BRI;
        uop.alu_fn     = op == OP_SW ? 6'd1 : 6'd3;
      end
      OP_LUI: begin
        uop.operation  = op;
        uop.rd         = rt;
        uop.has_rd     = 1'b1;
        uop.imm        = {instr[15:0], 16'h0};
        uop.rs_station = ST_BRI;
      end
      OP_SPECIAL: begin
        // R-type uops carry the funct as their operation since the opcode is always zero
        case (fn)
          FN_ADDU, FN_AND, FN_DIV: begin
            uop.operation  = fn;
            uop.rs1        = rs;
            uop.has_rs1    = 1'b1;
            uop.rs2        = rt;
            uop.has_rs2    = 1'b1;
            uop.rd         = fn == FN_DIV ? 5'd0 : rd;
            uop.has_rd     = fn != FN_DIV;
            uop.rs_station = fn == FN_DIV ? ST_MDU : ST_ALU;
            uop.alu_fn     = fn == FN_AND ? 6'd1 : 6'd0;
          end
          FN_MFHI, FN_MFLO: begin
            uop.operation  = fn;
            uop.rd         = rd;
            uop.has_rd     = 1'b1;
            uop.rs_station = ST_MDU;
            uop.alu_fn     = fn == FN_MFHI ? 6'd1 : 6'd2;
          end
          default: uop.illegal = 1'b1;
        endcase
      end
      default: uop.illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/decode_queue.sv
// decode_queue: decode-at-enqueue circular queue issuing up to ISSUE_W in-order uops per cycle.
module decode_queue
  import decode_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int ISSUE_W = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_instr,
  input  logic [31:0]              in_pc,
  output logic [ISSUE_W-1:0]       out_valid,
  input  logic [ISSUE_W-1:0]       out_ready,
  output uop_t [ISSUE_W-1:0]       out_uop,
  output logic [$clog2(DEPTH):0]   occupancy
);
  localparam int AW = $clog2(DEPTH);
  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [AW:0]   occ_q, occ_d, k;
  logic          enq, run;
  uop_t          dec_uop;
  uop_t          mem [DEPTH];
  uop_decode u_dec (.instr(in_instr), .pc(in_pc), .uop(dec_uop));
  assign in_ready  = occ_q != (AW+1)'(DEPTH);
  assign occupancy = occ_q;
  assign enq       = in_valid & in_ready;
  for (genvar g = 0; g < ISSUE_W; g++) begin : g_slot
    assign out_valid[g] = occ_q > (AW+1)'(g);
    assign out_uop[g]   = mem[head_q + AW'(g)];
  end
  // only the leading run of valid&ready slots retires, keeping dequeue in order
  always_comb begin
    k   = '0;
    run = 1'b1;
    for (int i = 0; i < ISSUE_W; i++) begin
      run = run & out_valid[i] & out_ready[i];
      k   = k + (AW+1)'(run);
    end
    head_d = flush ? '0 : head_q + k[AW-1:0];
    tail_d = flush ? '0 : tail_q + AW'(enq);
    occ_d  = flush ? '0 : occ_q + (AW+1)'(enq) - k;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
    end
  end
  always_ff @(posedge clk) begin
    if (enq && !flush) mem[tail_q] <= dec_uop;
  end
endmodule

// File: tb/tb_decode_queue.sv
// tb_decode_queue: directed checks of decode fields, occupancy, flush, reset and pointer wrap.
module tb_decode_queue;
  import decode_pkg::*;
  logic        clk = 1'b0, rst = 1'b1, flush = 1'b0, in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = '0, in_pc = '0;
  logic [1:0]  out_valid, out_ready = 2'b00;
  uop_t [1:0]  out_uop;
  logic [3:0]  occupancy;
  int          checks = 0, errors = 0;
  int          exp_occ, k_exp, pushed, popped;
  logic [31:0] next_pc = 32'h100;
  logic [31:0] pcq [$];
  logic [1:0]  pat [5] = '{2'b01, 2'b11, 2'b10, 2'b00, 2'b11};
  decode_queue #(.DEPTH(8), .ISSUE_W(2)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_uop(out_uop), .occupancy(occupancy)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic dv(input logic [31:0] instr, rd, rs1, rs2, has, imm, st, fn, ill);
    in_valid = 1'b1;
    in_instr = instr;
    in_pc    = next_pc;
    step();
    in_valid = 1'b0;
    check($sformatf("%h_occ", instr), 32'(occupancy), 1);
    check($sformatf("%h_valid", instr), 32'(out_valid), 1);
    check($sformatf("%h_pc", instr), out_uop[0].pc, next_pc);
    check($sformatf("%h_rd", instr), 32'(out_uop[0].rd), rd);
    check($sformatf("%h_rs1", instr), 32'(out_uop[0].rs1), rs1);
    check($sformatf("%h_rs2", instr), 32'(out_uop[0].rs2), rs2);
    check($sformatf("%h_has", instr),
          32'({out_uop[0].has_rd, out_uop[0].has_rs1, out_uop[0].has_rs2}), has);
    check($sformatf("%h_imm", instr), out_uop[0].imm, imm);
    check($sformatf("%h_st", instr), 32'(out_uop[0].rs_station), st);
    check($sformatf("%h_fn", instr), 32'(out_uop[0].alu_fn), fn);
    check($sformatf("%h_ill", instr), 32'(out_uop[0].illegal), ill);
    out_ready = 2'b01;
    step();
    out_ready = 2'b00;
    check($sformatf("%h_pop", instr), 32'(occupancy), 0);
    next_pc += 4;
  endtask
  initial begin
    step();
    step();
    rst = 1'b0;
    check("rst_occ", 32'(occupancy), 0);
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_out_valid", 32'(out_valid), 0);
    dv(32'h2402FFFF, 2, 0, 0, 3'b110, 32'hFFFFFFFF, 1, 0, 0);
    dv(32'h3042FFFF, 2, 2, 0, 3'b110, 32'h0000FFFF, 1, 2, 0);
    dv(32'h3C011234, 1, 0, 0, 3'b100, 32'h12340000, 3, 0, 0);
    dv(32'h1022FFFC, 0, 1, 2, 3'b011, 32'hFFFFFFFC, 3, 3, 0);
    dv(32'h8C830008, 3, 4, 0, 3'b110, 32'h00000008, 4, 0, 0);
    dv(32'hACC5FFF0, 0, 6, 5, 3'b011, 32'hFFFFFFF0, 4, 1, 0);
    dv(32'h01093821, 7, 8, 9, 3'b111, 0, 1, 0, 0);
    dv(32'h016C5024, 10, 11, 12, 3'b111, 0, 1, 1, 0);
    dv(32'h01AE001A, 0, 13, 14, 3'b011, 0, 2, 0, 0);
    dv(32'h00007810, 15, 0, 0, 3'b100, 0, 2, 1, 0);
    dv(32'h00008012, 16, 0, 0, 3'b100, 0, 2, 2, 0);
    dv(32'hFC000000, 0, 0, 0, 3'b000, 0, 0, 0, 1);
    dv(32'h00000000, 0, 0, 0, 3'b000, 0, 0, 0, 1);
    // fill to full with consumers stalled
    in_instr = 32'h2402FFFF;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_pc    = 32'h1000 + 32'(i * 4);
      step();
    end
    check("full_occ", 32'(occupancy), 8);
    check("full_in_ready", 32'(in_ready), 0);
    check("full_out_valid", 32'(out_valid), 3);
    in_pc     = 32'h2000;
    out_ready = 2'b11;
    step();
    check("full_deq_occ", 32'(occupancy), 6);
    check("full_deq_pc", out_uop[0].pc, 32'h1008);
    step();
    check("both_occ", 32'(occupancy), 5);
    check("both_pc", out_uop[0].pc, 32'h1010);
    in_valid  = 1'b0;
    out_ready = 2'b10;
    step();
    check("gap_occ", 32'(occupancy), 5);
    check("gap_pc", out_uop[0].pc, 32'h1010);
    flush     = 1'b1;
    in_valid  = 1'b1;
    out_ready = 2'b00;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush_occ", 32'(occupancy), 0);
    check("flush_out_valid", 32'(out_valid), 0);
    check("flush_in_ready", 32'(in_ready), 1);
    dv(32'hFC000000, 0, 0, 0, 3'b000, 0, 0, 0, 1);
    // asynchronous reset in the middle of a handshake
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_pc    = 32'h4000 + 32'(i * 4);
      step();
    end
    check("pre_rst_occ", 32'(occupancy), 3);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_occ", 32'(occupancy), 0);
    check("async_rst_valid", 32'(out_valid), 0);
    step();
    rst      = 1'b0;
    in_valid = 1'b0;
    check("post_rst_occ", 32'(occupancy), 0);
    check("post_rst_in_ready", 32'(in_ready), 1);
    pushed  = 0;
    popped  = 0;
    exp_occ = 0;
    for (int c = 0; c < 80 && !(pushed == 20 && exp_occ == 0); c++) begin
      in_valid  = pushed < 20;
      in_pc     = 32'h3000 + 32'(pushed * 4);
      out_ready = pushed < 20 ? pat[c % 5] : 2'b11;
      k_exp     = 0;
      for (int i = 0; i < 2; i++) begin
        if (k_exp == i && exp_occ > i && out_ready[i]) begin
          check("wrap_pc", out_uop[i].pc, pcq.pop_front());
          k_exp++;
          popped++;
        end
      end
      if (in_valid && exp_occ < 8) begin
        pcq.push_back(in_pc);
        pushed++;
        exp_occ++;
      end
      exp_occ -= k_exp;
      step();
      check("wrap_occ", 32'(occupancy), 32'(exp_occ));
    end
    in_valid  = 1'b0;
    out_ready = 2'b00;
    check("wrap_popped", popped, 20);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
